// File: rtl/sram_gated_pkg.sv
// sram_gated_pkg: shared types for the power-gated SRAM wrapper
package sram_gated_pkg;
  typedef enum logic [2:0] {ACTIVE, DRAIN, GATING, OFF, WAKING} pwr_state_e;
endpackage

// File: rtl/sram_gated_core.sv
// sram_gated_core: byte-enabled single-port array with a registered read, written for BRAM inference
module sram_gated_core #(
  parameter int NumWords  = 1024,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int BeWidth   = DataWidth / 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [BeWidth-1:0]   be,
  output logic [DataWidth-1:0] rdata
);
  logic [DataWidth-1:0] mem [NumWords];
  always_ff @(posedge clk) begin
    if (en && we)
      for (int k = 0; k < BeWidth; k++)
        if (be[k]) mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/sram_gated_wrapper.sv
// sram_gated_wrapper: SRAM wrapper with req/gnt handshake, configurable read latency and a
// power-gating sequencer that emulates retention/non-retention of an ASIC macro
module sram_gated_wrapper
  import sram_gated_pkg::*;
#(
  parameter int NumWords    = 1024,
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1,
  parameter int PwrDelay    = 4,
  parameter int AddrWidth   = NumWords > 1 ? $clog2(NumWords) : 1,
  parameter int BeWidth     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [BeWidth-1:0]   be_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  input  logic                 pwrgate_ni,
  output logic                 pwrgate_ack_no,
  input  logic                 set_retentive_ni
);
  localparam int CntWidth = PwrDelay > 1 ? $clog2(PwrDelay) : 1;
  pwr_state_e state, nxt;
  logic [CntWidth-1:0] cnt;
  logic [NumWords-1:0] valid;
  logic [DataWidth-1:0] core_rdata, masked;
  logic cnt_done, busy, acc, in_range, rd_v, hit;
  assign in_range = {1'b0, addr_i} < (AddrWidth + 1)'(NumWords);
  assign acc      = gnt_o & ~rst_i;
  assign cnt_done = cnt == CntWidth'(PwrDelay - 1);
  assign masked   = hit ? core_rdata : '0;
  always_ff @(posedge clk_i)
    state <= rst_i ? ACTIVE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      ACTIVE:  nxt = pwrgate_ni ? ACTIVE : DRAIN;
      DRAIN:   nxt = pwrgate_ni ? ACTIVE : busy ? DRAIN : GATING;
      GATING:  nxt = pwrgate_ni ? ACTIVE : cnt_done ? OFF : GATING;
      OFF:     nxt = pwrgate_ni ? WAKING : OFF;
      WAKING:  nxt = cnt_done ? ACTIVE : WAKING;
      default: nxt = ACTIVE;
    endcase
  end
  always_comb
    gnt_o = req_i & (state == ACTIVE) & pwrgate_ni;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt            <= '0;
      pwrgate_ack_no <= 1'b1;
    end else begin
      cnt            <= (state == nxt && (state == GATING || state == WAKING)) ? cnt + 1'b1 : '0;
      pwrgate_ack_no <= nxt != OFF && nxt != WAKING;
    end
  end
  // Non-retentive power-off forgets every word; the array itself keeps stale bits that are masked.
  always_ff @(posedge clk_i) begin
    if (rst_i) valid <= '1;
    else if (state == GATING && nxt == OFF && set_retentive_ni) valid <= '0;
    else if (acc && we_i && in_range) valid[addr_i] <= 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_v <= 1'b0;
      hit  <= 1'b0;
    end else begin
      rd_v <= acc & ~we_i;
      if (acc && !we_i) hit <= in_range & valid[addr_i];
    end
  end
  if (ReadLatency == 2) begin : g_lat2
    logic                 v2;
    logic [DataWidth-1:0] d2;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= rd_v;
        if (rd_v) d2 <= masked;
      end
    end
    assign rvalid_o = v2;
    assign rdata_o  = d2;
    assign busy     = rd_v | v2;
  end else begin : g_lat1
    assign rvalid_o = rd_v;
    assign rdata_o  = masked;
    assign busy     = rd_v;
  end
  sram_gated_core #(
    .NumWords (NumWords),
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth),
    .BeWidth  (BeWidth)
  ) u_core (
    .clk  (clk_i),
    .en   (acc & in_range),
    .we   (we_i),
    .addr (addr_i),
    .wdata(wdata_i),
    .be   (be_i),
    .rdata(core_rdata)
  );
endmodule

// File: tb/tb_sram_gated_wrapper.sv
// tb_sram_gated_wrapper: random traffic and power sequences against latency-1 and latency-2 wrappers
module tb_sram_gated_wrapper;
  localparam int NW = 20;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, pg = 1'b1, ret = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] be = '0;
  logic gnt1, gnt2, rv1, rv2, ack1, ack2;
  logic [31:0] rd1, rd2;
  int total = 0, bad = 0, e = 0;
  logic exp_g = 1'b0, pwr_on = 1'b1;
  logic [31:0] mem_m [NW];
  logic [NW-1:0] vld_m;
  typedef struct {int due; logic [31:0] d;} rd_t;
  rd_t q1[$], q2[$];
  logic [31:0] last1 = '0, last2 = '0;
  logic [31:0] b2b [3] = '{32'h1000_0000, 32'h1111_1111, 32'h2222_2222};

  always #5 clk = ~clk;

  sram_gated_wrapper #(.NumWords(NW), .DataWidth(32), .ReadLatency(1), .PwrDelay(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rv1), .rdata_o(rd1), .pwrgate_ni(pg),
    .pwrgate_ack_no(ack1), .set_retentive_ni(ret));
  sram_gated_wrapper #(.NumWords(NW), .DataWidth(32), .ReadLatency(2), .PwrDelay(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .rvalid_o(rv2), .rdata_o(rd2), .pwrgate_ni(pg),
    .pwrgate_ack_no(ack2), .set_retentive_ni(ret));

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  task automatic check1(input string n, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b", n, act, exp);
    end
  endtask

  // Memory model: granted accesses applied at the clock edge, reads queued with their due edge.
  always @(posedge clk) begin
    e++;
    if (rst) begin
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
      vld_m = '1;
    end else if (exp_g) begin
      if (we) begin
        if (int'(addr) < NW) begin
          for (int k = 0; k < 4; k++) if (be[k]) mem_m[addr][k*8 +: 8] = wdata[k*8 +: 8];
          vld_m[addr] = 1'b1;
        end
      end else begin
        logic [31:0] d;
        d = (int'(addr) < NW && vld_m[addr]) ? mem_m[addr] : '0;
        q1.push_back('{e, d});
        q2.push_back('{e + 1, d});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (q1.size() > 0 && q1[0].due == e) begin
      check1("rvalid1", rv1, 1'b1);
      last1 = q1[0].d;
      q1.delete(0);
    end else check1("rvalid1", rv1, 1'b0);
    check("rdata1", rd1, last1);
    if (q2.size() > 0 && q2[0].due == e) begin
      check1("rvalid2", rv2, 1'b1);
      last2 = q2[0].d;
      q2.delete(0);
    end else check1("rvalid2", rv2, 1'b0);
    check("rdata2", rd2, last2);
  end

  task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic p, input logic s, input logic x);
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d; be = b; pg = p; ret = s; rst = x;
    exp_g = r & pwr_on & p;
    #1;
    check1("gnt1", gnt1, exp_g);
    check1("gnt2", gnt2, exp_g);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    step(1'b1, 1'b1, a, d, b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic read_lit(input logic [4:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check1("lit_rvalid1", rv1, 1'b1);
    check("lit_rdata1", rd1, exp);
    idle();
    @(posedge clk); #1;
    check1("lit_rvalid2", rv2, 1'b1);
    check("lit_rdata2", rd2, exp);
  endtask

  task automatic rand_burst(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
    end
    idle();
    idle();
  endtask

  // Requests during the sequence are writes to addr 7 that must never be granted.
  task automatic power_down(input logic s);
    for (int j = 1; j <= 8; j++) begin
      step(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 4'hF, 1'b0, j <= 6 ? s : ~s, 1'b0);
      @(posedge clk); #1;
      check1("ack_down1", ack1, j < 6);
      check1("ack_down2", ack2, j < 6);
      if (j == 1) pwr_on = 1'b0;
      if (j == 6 && s) vld_m = '0;
    end
  endtask

  task automatic wake(input int n, input logic s);
    for (int j = 1; j <= n; j++) begin
      step(1'b1, 1'b0, 5'd7, 32'd0, 4'd0, 1'b1, ~s, 1'b0);
      @(posedge clk); #1;
      check1("ack_up1", ack1, j >= 5);
      check1("ack_up2", ack2, j >= 5);
      pwr_on = j >= 5;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 5'd3, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check1("rst_ack1", ack1, 1'b1);
    check1("rst_ack2", ack2, 1'b1);
    idle();
    for (int i = 0; i < NW; i++) wr(5'(i), $urandom, 4'hF);
    wr(5'd5, 32'hDEAD_BEEF, 4'hF);
    wr(5'd5, 32'h0000_0011, 4'h1);
    read_lit(5'd5, 32'hDEAD_BE11);
    read_lit(5'd25, 32'h0);
    for (int i = 0; i < 3; i++) wr(5'(i), b2b[i], 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) step(1'b1, 1'b0, 5'(i), 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      else idle();
      @(posedge clk); #1;
      check1("b2b_rvalid2", rv2, i >= 1 && i <= 3);
      if (i >= 1 && i <= 3) check("b2b_rdata2", rd2, b2b[i-1]);
    end
    rand_burst(200);
    wr(5'd7, 32'hA5A5_A5A5, 4'hF);
    idle(); idle();
    power_down(1'b0);
    wake(5, 1'b0);
    read_lit(5'd7, 32'hA5A5_A5A5);
    rand_burst(100);
    wr(5'd7, 32'hA5A5_A5A5, 4'hF);
    idle(); idle();
    power_down(1'b1);
    wake(5, 1'b1);
    read_lit(5'd7, 32'h0);
    wr(5'd7, 32'h1234_5678, 4'hF);
    read_lit(5'd7, 32'h1234_5678);
    rand_burst(100);
    wr(5'd7, 32'hA5A5_A5A5, 4'hF);
    idle(); idle();
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 4'hF, j == 4, 1'b1, 1'b0);
      @(posedge clk); #1;
      check1("abort_ack1", ack1, 1'b1);
      check1("abort_ack2", ack2, 1'b1);
      if (j == 1) pwr_on = 1'b0;
      if (j == 4) pwr_on = 1'b1;
    end
    read_lit(5'd7, 32'hA5A5_A5A5);
    rand_burst(100);
    wr(5'd7, 32'h5A5A_5A5A, 4'hF);
    idle(); idle();
    power_down(1'b0);
    wake(2, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    pwr_on = 1'b1;
    check1("wrst_ack1", ack1, 1'b1);
    check1("wrst_ack2", ack2, 1'b1);
    check1("wrst_rvalid1", rv1, 1'b0);
    check("wrst_rdata1", rd1, 32'h0);
    read_lit(5'd7, 32'h5A5A_5A5A);
    step(1'b1, 1'b0, 5'd7, 32'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check1("frst_rvalid2", rv2, 1'b0);
    check("frst_rdata2", rd2, 32'h0);
    check("frst_rdata1", rd1, 32'h0);
    read_lit(5'd7, 32'h5A5A_5A5A);
    rand_burst(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
